// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative right shifter.
// Optional rotate feature: SHIFT_RIGHT_ROTATE_EN.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;
    localparam int STEP_DEF    = 4;

    // Number of SHIFT cycles needed for a given amount and step size.
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/shift_right_iter_if.sv
// Request/response bundle between the controller and the right shifter.
// Handshake: the controller raises Start for a request; it is accepted on a
// rising edge only while Busy is low. Done pulses for one cycle when Out
// carries the new result; Out then holds until the next accepted Start.
// Optional rotate feature: SHIFT_RIGHT_ROTATE_EN (adds Rotate).
interface shift_right_iter_if
    import shift_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
);
    logic               Start;
    logic [WIDTH-1:0]   In;
    logic [SHAMT_W-1:0] Shamt;
    logic               Arith;
`ifdef SHIFT_RIGHT_ROTATE_EN
    logic               Rotate;
`endif
    logic               Busy;
    logic               Done;
    logic [WIDTH-1:0]   Out;

    modport master (
        output Start, In, Shamt, Arith,
`ifdef SHIFT_RIGHT_ROTATE_EN
        Rotate,
`endif
        input  Busy, Done, Out
    );

    modport slave (
        input  Start, In, Shamt, Arith,
`ifdef SHIFT_RIGHT_ROTATE_EN
        Rotate,
`endif
        output Busy, Done, Out
    );

endinterface

// File: rtl/shift_right_step.sv
// Combinational single-step right shift by n bits with a fill bit.
// Optional rotate path: SHIFT_RIGHT_ROTATE_EN.
module shift_right_step #(
    parameter int WIDTH = 32,
    parameter int NW    = 3
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [NW-1:0]    n_i,
    input  logic             fill_i,
`ifdef SHIFT_RIGHT_ROTATE_EN
    input  logic             rotate_i,
`endif
    output logic [WIDTH-1:0] data_o
);

    logic [2*WIDTH-1:0] ext;

    // Extend on the left with fill bits (or a copy of the data when rotating),
    // then shift the double-width word and keep the low half.
    always_comb begin
        ext = {{WIDTH{fill_i}}, data_i};
`ifdef SHIFT_RIGHT_ROTATE_EN
        if (rotate_i) begin
            ext = {data_i, data_i};
        end
`endif
        data_o = WIDTH'(ext >> n_i);
    end

endmodule

// File: rtl/shift_right_iter.sv
// Multi-cycle right shifter (SRL/SRA/SRLV/SRAV), up to STEP bits per clock.
// Optional rotate feature: SHIFT_RIGHT_ROTATE_EN.
// SHAMT_W must equal log2(WIDTH), so every shift amount is in range.
module shift_right_iter
    import shift_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF,
    parameter int STEP    = STEP_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    shift_right_iter_if.slave    bus,
    output state_e               dbg_state_o
);

    localparam int NW = $clog2(STEP + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   step_res;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               fill_q, fill_d;
    logic [NW-1:0]      n_step;
`ifdef SHIFT_RIGHT_ROTATE_EN
    logic               rot_q, rot_d;
`endif

    // Bits to shift this cycle: min(Rem, STEP).
    always_comb begin
        if (int'(rem_q) > STEP) begin
            n_step = NW'(STEP);
        end else begin
            n_step = NW'(rem_q);
        end
    end

    shift_right_step #(
        .WIDTH (WIDTH),
        .NW    (NW)
    ) u_step (
        .data_i   (work_q),
        .n_i      (n_step),
        .fill_i   (fill_q),
`ifdef SHIFT_RIGHT_ROTATE_EN
        .rotate_i (rot_q),
`endif
        .data_o   (step_res)
    );

    // Next-state logic: accept in IDLE/DONE, iterate in SHIFT.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        out_d   = out_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
`ifdef SHIFT_RIGHT_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.Start) begin
                    work_d = bus.In;
                    rem_d  = bus.Shamt;
                    fill_d = bus.Arith & bus.In[WIDTH-1];
`ifdef SHIFT_RIGHT_ROTATE_EN
                    rot_d  = bus.Rotate;
`endif
                    if (bus.Shamt == '0) begin
                        // Nothing to shift: result is ready straight away.
                        state_d = DONE;
                        out_d   = bus.In;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = step_res;
                rem_d  = rem_q - SHAMT_W'(n_step);
                if (rem_d == '0) begin
                    state_d = DONE;
                    out_d   = step_res;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight shift.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            out_q   <= '0;
            rem_q   <= '0;
            fill_q  <= 1'b0;
`ifdef SHIFT_RIGHT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
`ifdef SHIFT_RIGHT_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    assign bus.Busy    = (state_q == SHIFT);
    assign bus.Done    = (state_q == DONE);
    assign bus.Out     = out_q;
    assign dbg_state_o = state_q;

endmodule
